// File: rtl/std_dev_unit.sv
// Standard deviation unit: variance = E[x^2] - E[x]^2 (clamped at 0), then a
// restoring bit-serial integer square root. Optional STD_DEV_ROUND_EN adds a round-to-nearest cycle.
`timescale 1ns/1ps

module std_dev_unit #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     mean_in,
  input  logic [WIDTH-1:0]     sec_mom_in,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WIDTH-1:0]     var_out,
  output logic [WIDTH/2-1:0]   std_out,
  output logic                 clamped,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int RW   = WIDTH / 2;
  localparam int CW   = (RW > 1) ? $clog2(RW) : 1;
  // The partial remainder never exceeds 2*root, so RW+1 bits are enough.
  localparam int REMW = RW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_VAR,
    S_SQRT,
`ifdef STD_DEV_ROUND_EN
    S_ROUND,
`endif
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  mean_q, mean_d;
  logic [WIDTH-1:0]  sec_q, sec_d;
  logic [WIDTH-1:0]  rad_q, rad_d;
  logic [REMW-1:0]   rem_q, rem_d;
  logic [RW-1:0]     root_q, root_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  var_q, var_d;
  logic              clamp_q, clamp_d;
  logic [WIDTH-1:0]  var_out_q, var_out_d;
  logic [RW-1:0]     std_out_q, std_out_d;
  logic              clamped_out_q, clamped_out_d;

  logic [2*WIDTH-1:0] sq;
  logic               neg;
  logic [REMW+1:0]    rem_sh;
  logic [REMW+1:0]    trial;
  logic               take;
  logic [RW-1:0]      root_nxt;
`ifdef STD_DEV_ROUND_EN
  logic [RW-1:0]      root_rnd;
`endif

  always_comb begin
    state_d       = state_q;
    mean_d        = mean_q;
    sec_d         = sec_q;
    rad_d         = rad_q;
    rem_d         = rem_q;
    root_d        = root_q;
    cnt_d         = cnt_q;
    var_d         = var_q;
    clamp_d       = clamp_q;
    var_out_d     = var_out_q;
    std_out_d     = std_out_q;
    clamped_out_d = clamped_out_q;

    sq       = {{WIDTH{1'b0}}, mean_q} * {{WIDTH{1'b0}}, mean_q};
    // Sign of the wide difference: negative exactly when mean^2 exceeds sec_mom.
    neg      = sq > {{WIDTH{1'b0}}, sec_q};
    rem_sh   = {rem_q, rad_q[WIDTH-1 -: 2]};
    trial    = {1'b0, root_q, 2'b01};
    take     = rem_sh >= trial;
    root_nxt = {root_q[RW-2:0], take};
`ifdef STD_DEV_ROUND_EN
    // Round to nearest: remainder above root means sqrt >= root + 0.5.
    root_rnd = ((rem_q > {1'b0, root_q}) && (root_q != {RW{1'b1}})) ?
               root_q + RW'(1) : root_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          mean_d  = mean_in;
          sec_d   = sec_mom_in;
          state_d = S_VAR;
        end
      end
      S_VAR: begin
        if (neg) begin
          var_d   = '0;
          clamp_d = 1'b1;
          rad_d   = '0;
        end else begin
          var_d   = sec_q - sq[WIDTH-1:0];
          clamp_d = 1'b0;
          rad_d   = sec_q - sq[WIDTH-1:0];
        end
        root_d  = '0;
        rem_d   = '0;
        cnt_d   = CW'(RW - 1);
        state_d = S_SQRT;
      end
      S_SQRT: begin
        rem_d  = take ? REMW'(rem_sh - trial) : REMW'(rem_sh);
        root_d = root_nxt;
        rad_d  = {rad_q[WIDTH-3:0], 2'b00};
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == '0) begin
`ifdef STD_DEV_ROUND_EN
          state_d = S_ROUND;
`else
          var_out_d     = var_q;
          std_out_d     = root_nxt;
          clamped_out_d = clamp_q;
          state_d       = S_DONE;
`endif
        end
      end
`ifdef STD_DEV_ROUND_EN
      S_ROUND: begin
        var_out_d     = var_q;
        std_out_d     = root_rnd;
        clamped_out_d = clamp_q;
        state_d       = S_DONE;
      end
`endif
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      mean_q        <= '0;
      sec_q         <= '0;
      rad_q         <= '0;
      rem_q         <= '0;
      root_q        <= '0;
      cnt_q         <= '0;
      var_q         <= '0;
      clamp_q       <= 1'b0;
      var_out_q     <= '0;
      std_out_q     <= '0;
      clamped_out_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      mean_q        <= mean_d;
      sec_q         <= sec_d;
      rad_q         <= rad_d;
      rem_q         <= rem_d;
      root_q        <= root_d;
      cnt_q         <= cnt_d;
      var_q         <= var_d;
      clamp_q       <= clamp_d;
      var_out_q     <= var_out_d;
      std_out_q     <= std_out_d;
      clamped_out_q <= clamped_out_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign var_out   = var_out_q;
  assign std_out   = std_out_q;
  assign clamped   = clamped_out_q;

endmodule

// File: tb/tb_std_dev_unit.sv
// Self-checking bench for std_dev_unit: directed table, randomized ops against
// an arithmetic reference model, backpressure and mid-computation reset.
`timescale 1ns/1ps

module tb_std_dev_unit;

  localparam int WIDTH = 16;
  localparam int RW    = WIDTH / 2;
`ifdef STD_DEV_ROUND_EN
  localparam int EXP_LAT = RW + 3;
  localparam int STD57   = 8;
`else
  localparam int EXP_LAT = RW + 2;
  localparam int STD57   = 7;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] mean_in = '0;
  logic [WIDTH-1:0] sec_mom_in = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] var_out;
  logic [RW-1:0]    std_out;
  logic             clamped;
  logic             out_valid;
  logic             out_ready = 1'b0;

  int checks = 0;
  int failures = 0;

  std_dev_unit #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .mean_in(mean_in), .sec_mom_in(sec_mom_in),
    .in_valid(in_valid), .in_ready(in_ready), .var_out(var_out),
    .std_out(std_out), .clamped(clamped), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int mean;
    int sec;
    int exp_var;
    int exp_std;
    int exp_clamp;
  } vec_t;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic from the definition of variance and sqrt.
  task automatic model(input longint m, input longint s,
                       output longint v, output longint sd, output longint c);
    longint d;
    longint r;
    d = s - m * m;
    c = (d < 0) ? 1 : 0;
    v = (d < 0) ? 0 : d;
    r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
`ifdef STD_DEV_ROUND_EN
    if ((v - r * r) > r && r < (1 << RW) - 1) r++;
`endif
    sd = r;
  endtask

  // Called at posedge+1 with the DUT idle. Holds out_ready low for 'hold'
  // cycles in DONE, checking the held result against the captured one.
  task automatic do_op(input int m, input int s, input int hold,
                       output longint v, output longint sd, output longint c,
                       output int lat);
    int n;
    out_ready  = (hold == 0);
    mean_in    = WIDTH'(m);
    sec_mom_in = WIDTH'(s);
    in_valid   = 1'b1;
    @(posedge clk); #1;
    in_valid   = 1'b0;
    mean_in    = WIDTH'($urandom);
    sec_mom_in = WIDTH'($urandom);
    lat = 1;
    n   = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      lat++;
      n++;
    end
    v  = var_out;
    sd = std_out;
    c  = clamped;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_std", std_out, sd);
      chk("hold_var", var_out, v);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_valid", out_valid, 0);
    out_ready = 1'b0;
  endtask

  vec_t vecs[7];

  initial begin
    longint v, sd, c, ev, esd, ec;
    int lat, seen;

    vecs[0] = '{10, 136, 36, 6, 0};
    vecs[1] = '{20, 300, 0, 0, 1};
    vecs[2] = '{0, 65535, 65535, 255, 0};
    vecs[3] = '{0, 56, 56, 7, 0};
    vecs[4] = '{0, 57, 57, STD57, 0};
    vecs[5] = '{0, 50, 50, 7, 0};
    vecs[6] = '{0, 0, 0, 0, 0};

    #22 rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_std", std_out, 0);
    chk("rst_var", var_out, 0);
    chk("rst_clamped", clamped, 0);

    for (int i = 0; i < 7; i++) begin
      do_op(vecs[i].mean, vecs[i].sec, 0, v, sd, c, lat);
      chk($sformatf("vec%0d_var", i), v, vecs[i].exp_var);
      chk($sformatf("vec%0d_std", i), sd, vecs[i].exp_std);
      chk($sformatf("vec%0d_clamp", i), c, vecs[i].exp_clamp);
      chk($sformatf("vec%0d_lat", i), lat, EXP_LAT);
    end

    for (int i = 0; i < 40; i++) begin
      int m, s;
      m = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 65535) : $urandom_range(0, 300);
      s = $urandom_range(0, 65535);
      model(m, s, ev, esd, ec);
      do_op(m, s, $urandom_range(0, 3), v, sd, c, lat);
      chk($sformatf("rnd%0d_var m=%0d s=%0d", i, m, s), v, ev);
      chk($sformatf("rnd%0d_std m=%0d s=%0d", i, m, s), sd, esd);
      chk($sformatf("rnd%0d_clamp", i), c, ec);
      chk($sformatf("rnd%0d_lat", i), lat, EXP_LAT);
    end

    // Backpressure with new data pulsed while DONE is stalled.
    out_ready  = 1'b0;
    mean_in    = 16'd10;
    sec_mom_in = 16'd136;
    in_valid   = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    seen = 0;
    while (!out_valid && seen < 50) begin @(posedge clk); #1; seen++; end
    for (int i = 0; i < 5; i++) begin
      mean_in    = 16'd1;
      sec_mom_in = 16'd1;
      in_valid   = i[0] ? 1'b0 : 1'b1;
      chk("bp_in_ready", in_ready, 0);
      chk("bp_valid", out_valid, 1);
      chk("bp_var", var_out, 36);
      chk("bp_std", std_out, 6);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_release_valid", out_valid, 0);
    chk("bp_release_ready", in_ready, 1);
    chk("bp_retain_var", var_out, 36);
    chk("bp_retain_std", std_out, 6);
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("bp_dropped_no_result", seen, 0);

    // Reset during the 4th SQRT cycle.
    out_ready  = 1'b1;
    mean_in    = 16'd0;
    sec_mom_in = 16'd65535;
    in_valid   = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_std", std_out, 0);
    chk("midrst_var", var_out, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("midrst_no_result", seen, 0);
    chk("midrst_std_after", std_out, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/std_dev_unit.md
Name: std_dev_unit

Overview:
- Consumes the windowed mean (first moment) and mean-of-squares (second moment) produced by the moving-statistics blocks.
- Computes variance = E[x²] − (E[x])², then its integer square root (standard deviation) with a sequential bit-serial algorithm.
- Undoes the squaring performed upstream and feeds the volatility result to strategy logic over a valid/ready handshake.

Parameters:
- WIDTH, 16, width of mean, second-moment and variance words; must be even, ≥4.
- Derived (not overridable): RW = WIDTH/2, the root width.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- mean_in  in  WIDTH  windowed mean, unsigned
- sec_mom_in  in  WIDTH  windowed mean of squares, unsigned
- in_valid  in  1  input operands valid
- in_ready  out  1  block can accept operands
- var_out  out  WIDTH  variance, unsigned, clamped at 0
- std_out  out  RW  standard deviation
- clamped  out  1  variance was negative and forced to 0
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: FSM to IDLE; in_ready=1; out_valid=0; var_out=0; std_out=0; clamped=0; all internal registers 0.
- FSM states: IDLE, VAR, SQRT, DONE.
- IDLE:
  - in_ready=1.
  - If in_valid is high on a rising edge, latch mean_in and sec_mom_in, then go to VAR.
- VAR (1 cycle):
  - Compute sq = mean² in 2·WIDTH bits.
  - diff = sec_mom − sq, evaluated in 2·WIDTH+1 bits signed.
  - If diff<0: variance=0 and clamped=1. Otherwise variance=diff[WIDTH-1:0] and clamped=0. diff cannot exceed 2^WIDTH−1.
  - Initialise root=0, rem=0, radicand=variance, iteration counter=RW−1. Go to SQRT.
- SQRT (exactly RW cycles): restoring bit-serial square root, one root bit per cycle, MSB first.
  - rem ← (rem<<2) | top two radicand bits; radicand shifts left by 2.
  - trial = (root<<2)|1.
  - If rem ≥ trial: rem ← rem − trial and root ← (root<<1)|1. Otherwise root ← root<<1.
  - Counter decrements. After the counter-0 iteration, go to DONE.
  - Result is floor(sqrt(variance)).
- DONE:
  - out_valid=1; var_out, std_out and clamped are stable and held.
  - When out_valid && out_ready on a rising edge, go to IDLE.
  - The outputs retain their values after the transfer; out_valid drops.
- Handshake and latency:
  - in_ready=0 in VAR, SQRT and DONE; in_valid is ignored there. No skid buffer and no pipelining: one operation in flight.
  - Latency: out_valid asserts RW+2 rising edges after the accepting edge (10 for WIDTH=16).
  - Throughput: one result per RW+3 cycles if out_ready is held high.
- Boundary conditions:
  - out_ready=0 in DONE: hold indefinitely; results must not change.
  - out_ready high before DONE has no effect.
  - mean_in/sec_mom_in changing after acceptance have no effect.
  - Reset asserted in any state (including mid-SQRT) immediately forces the reset values. No partial result is ever presented.
  - mean_in=0: variance=sec_mom.
  - variance=0: std=0.
  - Maximum variance 2^WIDTH−1 gives std=2^RW−1.

Optional Feature:
- Macro: STD_DEV_ROUND_EN.
- Defined:
  - After SQRT, one extra ROUND cycle is inserted before DONE; latency becomes RW+3.
  - If final rem > root, std_out=root+1, else root; this is round-to-nearest, since (r+0.5)² = r²+r+0.25.
  - The result saturates at 2^RW−1.
- Undefined: no ROUND state; std_out=floor(sqrt(variance)); latency RW+2.

Test Plan:
- Reset, then idle with rst low → in_ready=1, out_valid=0, std_out=0, var_out=0, clamped=0.
- mean=10, sec_mom=136, in_valid one cycle, out_ready=1 → var_out=36, std_out=6, clamped=0. out_valid rises exactly 10 edges after acceptance (11 with STD_DEV_ROUND_EN).
- mean=20, sec_mom=300 → var_out=0, clamped=1, std_out=0.
- mean=0, sec_mom=65535 → var_out=65535, std_out=255 in both builds (rounding saturates).
- Rounding set, mean=0:
  - sec_mom=56 → std_out=7 in both builds.
  - sec_mom=57 → 7 without macro, 8 with.
  - sec_mom=50 → 7 in both builds.
- Backpressure and reset:
  - out_ready=0 for 5 cycles in DONE while in_valid is pulsed with new data → outputs held, in_ready=0, new data dropped. Raising out_ready returns the FSM to IDLE.
  - Separately, assert rst during the 4th SQRT cycle → out_valid=0, in_ready=1 immediately, and no result is emitted.
